// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes the ALU control word, resolves operand forwarding
// at capture, and keeps refreshing forwarded operands while the stage is stalled.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [RA_W-1:0] rs1,
    input  logic [RA_W-1:0] rs2,
    input  logic [RA_W-1:0] rd,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic            flush,
    input  logic            exm_we,
    input  logic [RA_W-1:0] exm_rd,
    input  logic [XLEN-1:0] exm_data,
    input  logic            mwb_we,
    input  logic [RA_W-1:0] mwb_rd,
    input  logic [XLEN-1:0] mwb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [5:0]      alu_ctrl,
    output logic [RA_W-1:0] out_rd,
    output logic            out_reg_write,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_CUST0 = 7'b0001011;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b0111;
    localparam logic [3:0] ALU_LUI = 4'b1000;

    localparam logic [5:0] CTRL_ILLEGAL = 6'b001111;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] alu_a_q, alu_a_d;
    logic [XLEN-1:0] alu_b_q, alu_b_d;
    logic [5:0]      alu_ctrl_q, alu_ctrl_d;
    logic [RA_W-1:0] out_rd_q, out_rd_d;
    logic            reg_write_q, reg_write_d;
    logic            illegal_q, illegal_d;
    logic [RA_W-1:0] rs1_q, rs1_d;
    logic [RA_W-1:0] rs2_q, rs2_d;
    logic            use_imm_q, use_imm_d;

    logic            dec_legal;
    logic [3:0]      dec_op;
    logic [1:0]      dec_mode;
    logic            dec_use_imm;
    logic            dec_zero_a;
    logic [RA_W-1:0] src1;
    logic            capture;

    // Forwarding priority: EX/MEM, then MEM/WB, then the fallback value; x0 is always 0.
    function automatic logic [XLEN-1:0] fwd(input logic [RA_W-1:0] rs,
                                            input logic [XLEN-1:0] fallback);
        if (rs == '0)                     return '0;
        else if (exm_we && exm_rd == rs)  return exm_data;
        else if (mwb_we && mwb_rd == rs)  return mwb_data;
        else                              return fallback;
    endfunction

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        dec_legal   = 1'b1;
        dec_op      = ALU_ADD;
        dec_mode    = 2'b00;
        dec_use_imm = 1'b0;
        dec_zero_a  = 1'b0;
        case (opcode)
            OPC_OP, OPC_OPIMM: begin
                dec_use_imm = (opcode == OPC_OPIMM);
                case (funct3)
                    3'b000:  dec_op = (funct7[5] && !dec_use_imm) ? ALU_SUB : ALU_ADD;
                    3'b111:  dec_op = ALU_AND;
                    3'b110:  dec_op = ALU_OR;
                    3'b100:  dec_op = ALU_XOR;
                    3'b001:  dec_op = ALU_SLL;
                    3'b101:  dec_op = funct7[5] ? ALU_SRA : ALU_SRL;
                    default: dec_legal = 1'b0;
                endcase
            end
            OPC_LUI: begin
                dec_op      = ALU_LUI;
                dec_use_imm = 1'b1;
                dec_zero_a  = 1'b1;
            end
            OPC_CUST0: begin
                case (funct7)
                    7'b0000001: dec_mode = 2'b01;
                    7'b0000010: dec_mode = 2'b10;
                    default:    dec_legal = 1'b0;
                endcase
                case (funct3)
                    3'b000:  dec_op = ALU_ADD;
                    3'b001:  dec_op = ALU_SUB;
                    3'b010:  dec_op = ALU_AND;
                    3'b011:  dec_op = ALU_OR;
                    default: dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    assign in_ready = !out_valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;
    // LUI stores x0 as its first source so stall refresh can never disturb alu_a.
    assign src1     = dec_zero_a ? '0 : rs1;

    always_comb begin
        out_valid_d = out_valid_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_ctrl_d  = alu_ctrl_q;
        out_rd_d    = out_rd_q;
        reg_write_d = reg_write_q;
        illegal_d   = illegal_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        use_imm_d   = use_imm_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d = 1'b1;
            alu_a_d     = fwd(src1, rs1_data);
            alu_b_d     = dec_use_imm ? imm : fwd(rs2, rs2_data);
            alu_ctrl_d  = dec_legal ? {dec_mode, dec_op} : CTRL_ILLEGAL;
            out_rd_d    = rd;
            reg_write_d = dec_legal && (rd != '0);
            illegal_d   = !dec_legal;
            rs1_d       = src1;
            rs2_d       = rs2;
            use_imm_d   = dec_use_imm;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else if (out_valid_q) begin
            alu_a_d = fwd(rs1_q, alu_a_q);
            if (!use_imm_q) begin
                alu_b_d = fwd(rs2_q, alu_b_q);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_ctrl_q  <= '0;
            out_rd_q    <= '0;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            use_imm_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_ctrl_q  <= alu_ctrl_d;
            out_rd_q    <= out_rd_d;
            reg_write_q <= reg_write_d;
            illegal_q   <= illegal_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            use_imm_q   <= use_imm_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_ctrl      = alu_ctrl_q;
    assign out_rd        = out_rd_q;
    assign out_reg_write = reg_write_q;
    assign out_illegal   = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed instructions push hand-computed results,
// a negedge monitor pops and compares each transfer toward EX.
module tb_id_ex_stage;

    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] C0  = 7'b0001011;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  ctrl;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
        logic        cab;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [6:0]  opcode = '0, funct7 = '0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic [31:0] rs1_data = '0, rs2_data = '0, imm = '0;
    logic        flush = 1'b0;
    logic        exm_we = 1'b0, mwb_we = 1'b0;
    logic [4:0]  exm_rd = '0, mwb_rd = '0;
    logic [31:0] exm_data = '0, mwb_data = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] alu_a, alu_b;
    logic [5:0]  alu_ctrl;
    logic [4:0]  out_rd;
    logic        out_reg_write, out_illegal;

    int   checks = 0;
    int   errors = 0;
    int   pops = 0;
    int   base;
    exp_t sb[$];

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs1(rs1), .rs2(rs2), .rd(rd), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm(imm), .flush(flush),
        .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data),
        .mwb_we(mwb_we), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [5:0] c, input logic [4:0] r,
                                input logic rw, input logic ill, input logic cab);
        exp_t e;
        e.a = a; e.b = b; e.ctrl = c; e.rd = r; e.rw = rw; e.ill = ill; e.cab = cab;
        return e;
    endfunction

    // Presents one instruction for one cycle; returns 1 time unit after the edge.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                         input logic [31:0] x1, input logic [31:0] x2, input logic [31:0] im,
                         input exp_t e, input bit push);
        opcode = op; funct3 = f3; funct7 = f7;
        rs1 = r1; rs2 = r2; rd = d;
        rs1_data = x1; rs2_data = x2; imm = im;
        in_valid = 1'b1;
        if (push) sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got ctrl 0x%0h with empty scoreboard", alu_ctrl);
            end else begin
                exp_t e;
                e = sb.pop_front();
                pops++;
                if (e.cab) begin
                    check("alu_a", alu_a, e.a);
                    check("alu_b", alu_b, e.b);
                end
                check("alu_ctrl", {26'd0, alu_ctrl}, {26'd0, e.ctrl});
                check("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
                check("out_reg_write", {31'd0, out_reg_write}, {31'd0, e.rw});
                check("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_ctrl", {26'd0, alu_ctrl}, 32'd0);
        check("rst_flags", {27'd0, out_rd, out_reg_write, out_illegal}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Decode coverage, streamed back to back.
        issue(OP, 3'b000, 7'h00, 1, 2, 3, 5, 7, 0, mk(5, 7, 6'b000000, 3, 1, 0, 1), 1);
        issue(OP, 3'b000, 7'h20, 1, 2, 4, 9, 4, 0, mk(9, 4, 6'b000001, 4, 1, 0, 1), 1);
        issue(OPI, 3'b101, 7'h20, 1, 3, 5, 32'h80, 32'h99, 3, mk(32'h80, 3, 6'b000111, 5, 1, 0, 1), 1);
        issue(OPI, 3'b000, 7'h20, 1, 16, 6, 32'h80, 32'h99, 32'h10, mk(32'h80, 32'h10, 6'b000000, 6, 1, 0, 1), 1);
        issue(C0, 3'b001, 7'h01, 1, 2, 7, 32'h01020304, 32'h01010101, 0,
              mk(32'h01020304, 32'h01010101, 6'b010001, 7, 1, 0, 1), 1);
        issue(C0, 3'b000, 7'h02, 1, 2, 8, 32'h10, 32'h20, 0, mk(32'h10, 32'h20, 6'b100000, 8, 1, 0, 1), 1);
        issue(C0, 3'b000, 7'h03, 1, 2, 9, 1, 2, 0, mk(0, 0, 6'b001111, 9, 0, 1, 0), 1);
        issue(C0, 3'b100, 7'h01, 1, 2, 9, 1, 2, 0, mk(0, 0, 6'b001111, 9, 0, 1, 0), 1);
        issue(OP, 3'b010, 7'h00, 1, 2, 9, 1, 2, 0, mk(0, 0, 6'b001111, 9, 0, 1, 0), 1);
        issue(7'h7F, 3'b000, 7'h00, 1, 2, 9, 1, 2, 0, mk(0, 0, 6'b001111, 9, 0, 1, 0), 1);
        issue(LUI, 3'b000, 7'h00, 9, 0, 10, 32'h77, 0, 32'h12345000,
              mk(0, 32'h12345000, 6'b001000, 10, 1, 0, 1), 1);
        issue(OP, 3'b000, 7'h00, 1, 2, 0, 5, 7, 0, mk(5, 7, 6'b000000, 0, 0, 0, 1), 1);

        // Forwarding priority and x0.
        exm_we = 1'b1; exm_rd = 4; exm_data = 32'hAA;
        mwb_we = 1'b1; mwb_rd = 4; mwb_data = 32'hBB;
        issue(OP, 3'b000, 7'h00, 4, 2, 3, 1, 3, 0, mk(32'hAA, 3, 6'b000000, 3, 1, 0, 1), 1);
        issue(OP, 3'b000, 7'h00, 0, 2, 3, 32'h123, 3, 0, mk(0, 3, 6'b000000, 3, 1, 0, 1), 1);
        exm_we = 1'b0;
        issue(OP, 3'b000, 7'h00, 1, 4, 3, 32'h11, 32'h22, 0, mk(32'h11, 32'hBB, 6'b000000, 3, 1, 0, 1), 1);
        mwb_we = 1'b0;
        @(posedge clk); #1;
        check("drain_valid", {31'd0, out_valid}, 32'd0);

        // Four back-to-back transfers with no bubble.
        base = pops;
        issue(OP, 3'b111, 7'h00, 1, 2, 11, 32'hF0, 32'h3C, 0, mk(32'hF0, 32'h3C, 6'b000010, 11, 1, 0, 1), 1);
        issue(OP, 3'b110, 7'h00, 1, 2, 12, 32'hF0, 32'h3C, 0, mk(32'hF0, 32'h3C, 6'b000011, 12, 1, 0, 1), 1);
        issue(OP, 3'b100, 7'h00, 1, 2, 13, 32'hF0, 32'h3C, 0, mk(32'hF0, 32'h3C, 6'b000100, 13, 1, 0, 1), 1);
        issue(OP, 3'b101, 7'h00, 1, 2, 14, 32'hF0, 32'h3C, 0, mk(32'hF0, 32'h3C, 6'b000110, 14, 1, 0, 1), 1);
        @(posedge clk); #1;
        check("stream_transfers", pops - base, 32'd4);

        // Stall with a MEM/WB refresh of alu_b in stall cycle 2.
        out_ready = 1'b0;
        issue(OP, 3'b000, 7'h00, 5, 6, 7, 32'h20, 32'h10, 0, mk(32'h20, 32'h55, 6'b000000, 7, 1, 0, 1), 1);
        check("stall1_in_ready", {31'd0, in_ready}, 32'd0);
        check("stall1_alu_b", alu_b, 32'h10);
        @(posedge clk); #1;
        mwb_we = 1'b1; mwb_rd = 6; mwb_data = 32'h55;
        check("stall2_in_ready", {31'd0, in_ready}, 32'd0);
        check("stall2_alu_b", alu_b, 32'h10);
        @(posedge clk); #1;
        mwb_we = 1'b0;
        check("stall3_in_ready", {31'd0, in_ready}, 32'd0);
        check("stall3_valid", {31'd0, out_valid}, 32'd1);
        check("stall3_alu_a", alu_a, 32'h20);
        check("stall3_alu_b", alu_b, 32'h55);
        check("stall3_rd", {27'd0, out_rd}, 32'd7);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_stall_valid", {31'd0, out_valid}, 32'd0);

        // Flush during a stall, then flush blocking a capture.
        out_ready = 1'b0;
        issue(OP, 3'b000, 7'h00, 1, 2, 3, 5, 7, 0, '0, 0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_stall_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        flush = 1'b1;
        issue(OP, 3'b000, 7'h00, 1, 2, 3, 5, 7, 0, '0, 0);
        flush = 1'b0;
        check("flush_blocks_capture", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset while stalled.
        issue(OP, 3'b000, 7'h00, 1, 2, 3, 5, 7, 0, '0, 0);
        check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("async_rst_alu_a", alu_a, 32'd0);
        check("async_rst_alu_b", alu_b, 32'd0);
        check("async_rst_flags", {21'd0, alu_ctrl, out_rd, out_reg_write, out_illegal}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        issue(OP, 3'b000, 7'h20, 1, 2, 3, 8, 3, 0, mk(8, 3, 6'b000001, 3, 1, 0, 1), 1);
        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
